scan_pattern_sequencer: RTL and testbench

//  On-chip scan test sequencer for the b03 arbiter core (chain via test_si/test_so/test_se).
//  Per pattern: shifts a stimulus vector in while unloading the previous capture and comparing it

---
 rtl/scan_seq_pkg.sv | 14 +
 rtl/scan_cmp_unit.sv | 63 ++++++
 rtl/scan_pattern_sequencer.sv | 147 ++++++++++++++
 tb/tb_scan_pattern_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the scan pattern sequencer.
package scan_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCapture,
    StDone
  } state_e;

  localparam int unsigned FAIL_CNT_W = 16;
  localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_MAX = '1;

endpackage

// File: rtl/scan_cmp_unit.sv
// Masked unload compare: sticky fail, saturating miscompare count, first-fail position.
module scan_cmp_unit
  import scan_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmp_en,
  input  logic                  so_bit,
  input  logic                  exp_bit,
  input  logic [CNT_W-1:0]      pos,
  input  logic                  clear_fail,
  output logic                  fail,
  output logic [FAIL_CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0]      first_fail_pos
);

  logic                  fail_q, fail_d;
  logic [FAIL_CNT_W-1:0] fail_count_q, fail_count_d;
  logic [CNT_W-1:0]      first_q, first_d;
  logic                  miscompare;

  assign miscompare = cmp_en & (so_bit != exp_bit);

  always_comb begin
    fail_d       = fail_q;
    fail_count_d = fail_count_q;
    first_d      = first_q;
    if (miscompare) begin
      // A new miscompare outranks clear_fail in the same cycle.
      fail_d = 1'b1;
      if (clear_fail) begin
        fail_count_d = FAIL_CNT_W'(1);
      end else if (fail_count_q != FAIL_CNT_MAX) begin
        fail_count_d = fail_count_q + FAIL_CNT_W'(1);
      end
      if (!fail_q || clear_fail) begin
        first_d = pos;
      end
    end else if (clear_fail) begin
      fail_d       = 1'b0;
      fail_count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fail_q       <= 1'b0;
      fail_count_q <= '0;
      first_q      <= '0;
    end else begin
      fail_q       <= fail_d;
      fail_count_q <= fail_count_d;
      first_q      <= first_d;
    end
  end

  assign fail           = fail_q;
  assign fail_count     = fail_count_q;
  assign first_fail_pos = first_q;

endmodule

// File: rtl/scan_pattern_sequencer.sv
// Scan pattern sequencer: shift-in stimulus / unload-compare, capture pulses, done handshake.
module scan_pattern_sequencer
  import scan_seq_pkg::*;
#(
  parameter int unsigned CHAIN_LEN      = 30,
  parameter int unsigned CAPTURE_CYCLES = 1,
  parameter int unsigned CNT_W          = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  unload_only,
  input  logic [CHAIN_LEN-1:0]  load_data,
  input  logic [CHAIN_LEN-1:0]  exp_data,
  input  logic [CHAIN_LEN-1:0]  exp_mask,
  input  logic                  clear_fail,
  output logic                  ready,
  output logic                  scan_se,
  output logic                  scan_si,
  input  logic                  scan_so,
  output logic                  done,
  output logic                  fail,
  output logic [FAIL_CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0]      first_fail_pos
);

  localparam logic [CNT_W-1:0] ShiftLast = CNT_W'(CHAIN_LEN - 1);
  localparam logic [1:0]       CapLast   = 2'(CAPTURE_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [1:0]            cap_q, cap_d;
  logic [CHAIN_LEN-1:0]  load_q, load_d;
  logic [CHAIN_LEN-1:0]  exp_q, exp_d;
  logic [CHAIN_LEN-1:0]  mask_q, mask_d;
  logic                  mode_q, mode_d;
  logic                  armed_q, armed_d;
  logic                  scan_se_q, scan_se_d;
  logic                  scan_si_q, scan_si_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic                  cmp_en;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cap_d   = cap_q;
    load_d  = load_q;
    exp_d   = exp_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    armed_d = armed_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load_d  = load_data;
          exp_d   = exp_data;
          mask_d  = exp_mask;
          mode_d  = unload_only;
          count_d = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        load_d  = load_q >> 1;
        exp_d   = exp_q >> 1;
        mask_d  = mask_q >> 1;
        count_d = count_q + CNT_W'(1);
        cap_d   = '0;
        if (count_q == ShiftLast) begin
          state_d = mode_q ? StDone : StCapture;
        end
      end
      StCapture: begin
        cap_d = cap_q + 2'd1;
        if (cap_q == CapLast) begin
          armed_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        // An unload-only pass leaves no fresh capture in the chain.
        if (mode_q) armed_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from next state so they come straight out of flops.
    scan_se_d = (state_d == StShift);
    scan_si_d = scan_se_d & load_d[0];
    done_d    = (state_d == StDone);
    ready_d   = (state_d == StIdle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      cap_q     <= '0;
      load_q    <= '0;
      exp_q     <= '0;
      mask_q    <= '0;
      mode_q    <= 1'b0;
      armed_q   <= 1'b0;
      scan_se_q <= 1'b0;
      scan_si_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      cap_q     <= cap_d;
      load_q    <= load_d;
      exp_q     <= exp_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      armed_q   <= armed_d;
      scan_se_q <= scan_se_d;
      scan_si_q <= scan_si_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign cmp_en  = (state_q == StShift) & armed_q & mask_q[0];
  assign ready   = ready_q;
  assign scan_se = scan_se_q;
  assign scan_si = scan_si_q;
  assign done    = done_q;

  scan_cmp_unit #(
    .CNT_W (CNT_W)
  ) u_cmp (
    .clock          (clock),
    .reset          (reset),
    .cmp_en         (cmp_en),
    .so_bit         (scan_so),
    .exp_bit        (exp_q[0]),
    .pos            (count_q),
    .clear_fail     (clear_fail),
    .fail           (fail),
    .fail_count     (fail_count),
    .first_fail_pos (first_fail_pos)
  );

endmodule

// File: tb/tb_scan_pattern_sequencer.sv
// Bench: 8-flop behavioural chain whose capture inverts its contents, plus a pattern-level model.
module tb_scan_pattern_sequencer;

  localparam int N = 8;
  localparam int C = 1;

  logic        clock, reset, start, unload_only, clear_fail;
  logic [7:0]  load_data, exp_data, exp_mask;
  logic        ready, scan_se, scan_si, scan_so, done, fail;
  logic [15:0] fail_count;
  logic [3:0]  first_fail_pos;

  int n_checks = 0;
  int n_errors = 0;

  // Pattern-level reference state
  bit          m_armed, m_fail;
  int unsigned m_cnt;
  int          m_first;
  logic [7:0]  m_img;

  scan_pattern_sequencer #(
    .CHAIN_LEN      (N),
    .CAPTURE_CYCLES (C)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .unload_only    (unload_only),
    .load_data      (load_data),
    .exp_data       (exp_data),
    .exp_mask       (exp_mask),
    .clear_fail     (clear_fail),
    .ready          (ready),
    .scan_se        (scan_se),
    .scan_si        (scan_si),
    .scan_so        (scan_so),
    .done           (done),
    .fail           (fail),
    .fail_count     (fail_count),
    .first_fail_pos (first_fail_pos)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Chain under test: shifts while scan_se=1, captures ~state once on the first functional edge.
  logic [7:0] chain = 8'h00;
  logic       prev_se = 1'b0;
  always @(posedge clock) begin
    prev_se <= scan_se;
    if (scan_se) chain <= {scan_si, chain[7:1]};
    else if (prev_se) chain <= ~chain;
  end
  assign scan_so = chain[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_fail = 0; m_cnt = 0; m_first = 0;
  endtask

  task automatic model_bit(input int i, input logic ex, input logic mk, input bit clr);
    bit mis;
    mis = m_armed && mk && (m_img[i] !== ex);
    if (mis) begin
      if (!m_fail || clr) m_first = i;
      m_fail = 1;
      if (clr) m_cnt = 1;
      else if (m_cnt < 32'hFFFF) m_cnt++;
    end else if (clr) begin
      m_fail = 0;
      m_cnt  = 0;
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_fail"}, 32'(fail), 32'(m_fail));
    chk({tag, "_count"}, 32'(fail_count), m_cnt);
    chk({tag, "_first"}, 32'(first_fail_pos), 32'(m_first));
  endtask

  // Called at a negedge with ready expected high; returns at the negedge of the cycle after done.
  task automatic run_pattern(input logic [7:0] ld, input logic [7:0] ex, input logic [7:0] mk,
                             input bit uo, input int clr_at);
    int   dc;
    logic si_exp;
    dc = uo ? N + 1 : N + C + 1;
    chk("ready_idle", 32'(ready), 32'd1);
    load_data   = ld;
    exp_data    = ex;
    exp_mask    = mk;
    unload_only = uo;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= dc; k++) begin
      si_exp = 1'b0;
      if (k <= N) si_exp = ld[k-1];
      chk("scan_se", 32'(scan_se), 32'(k <= N));
      chk("scan_si", 32'(scan_si), 32'(si_exp));
      chk("done", 32'(done), 32'(k == dc));
      chk("ready_busy", 32'(ready), 32'd0);
      start      = (k == 3);  // must be ignored while busy
      clear_fail = (clr_at == k);
      if (k <= N) model_bit(k - 1, ex[k-1], mk[k-1], clr_at == k);
      @(negedge clock);
    end
    start      = 1'b0;
    clear_fail = 1'b0;
    if (uo) begin
      m_armed = 0; m_img = ld;
    end else begin
      m_armed = 1; m_img = ~ld;
    end
    chk("ready_back", 32'(ready), 32'd1);
    chk("done_low", 32'(done), 32'd0);
    chk_status("pat");
  endtask

  initial begin
    logic [7:0] ld, ex, mk;
    bit         uo;
    int         clr;

    reset = 1'b0; start = 1'b0; unload_only = 1'b0; clear_fail = 1'b0;
    load_data = '0; exp_data = '0; exp_mask = '0;
    model_reset();
    m_img = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_se", 32'(scan_se), 32'd0);
    chk("rst_si", 32'(scan_si), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_status("rst");
    reset = 1'b1;
    @(negedge clock);

    // First pattern after reset: unarmed, no compare
    run_pattern(8'hA5, 8'h00, 8'hFF, 0, -1);
    chk("p1_fail", 32'(fail), 32'd0);

    // Unload of ~A5 against matching and one-bit-off expectations
    run_pattern(8'hA5, 8'h5A, 8'hFF, 0, -1);
    chk("p2_fail", 32'(fail), 32'd0);
    run_pattern(8'hA5, 8'h5A ^ 8'h04, 8'hFF, 0, -1);
    chk("p3_fail", 32'(fail), 32'd1);
    chk("p3_count", 32'(fail_count), 32'd1);
    chk("p3_first", 32'(first_fail_pos), 32'd2);

    // Idle clear, then the same miscompare masked off
    clear_fail = 1'b1; m_fail = 0; m_cnt = 0;
    @(negedge clock);
    clear_fail = 1'b0;
    chk("clr_fail", 32'(fail), 32'd0);
    chk("clr_count", 32'(fail_count), 32'd0);
    run_pattern(8'hA5, 8'h5A ^ 8'h04, 8'hFB, 0, -1);
    chk("mask_fail", 32'(fail), 32'd0);

    // Unload-only pass, then a pattern that must not compare
    run_pattern(8'h3C, 8'h5A, 8'hFF, 1, -1);
    run_pattern(8'h0F, 8'h00, 8'hFF, 0, -1);
    chk("after_uo_fail", 32'(fail), 32'd0);

    // Asynchronous reset during shift cycle 4
    load_data = 8'hC3; exp_data = 8'h00; exp_mask = 8'hFF; unload_only = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort_se_pre", 32'(scan_se), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    chk("abort_se", 32'(scan_se), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk_status("abort");
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    run_pattern(8'h81, 8'h00, 8'hFF, 0, -1);

    // Randomized patterns
    for (int it = 0; it < 30; it++) begin
      ld  = 8'($urandom);
      mk  = 8'($urandom);
      uo  = ($urandom_range(0, 4) == 0);
      ex  = ($urandom_range(0, 1) == 0) ? 8'($urandom) : (m_img ^ (8'h01 << $urandom_range(0, 7)));
      clr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, N)) : -1;
      run_pattern(ld, ex, mk, uo, clr);
      if ($urandom_range(0, 3) == 0) @(negedge clock);
    end

    // Saturation: preload the counter near the top, then drive full-width miscompares
    run_pattern(8'h66, 8'h00, 8'h00, 0, -1);
    force dut.u_cmp.fail_count_q = 16'hFFF8;
    @(negedge clock);
    @(negedge clock);
    release dut.u_cmp.fail_count_q;
    m_cnt = 32'hFFF8;
    chk("sat_preload", 32'(fail_count), 32'hFFF8);
    run_pattern(8'h99, ~m_img, 8'hFF, 0, -1);
    chk("sat_count", 32'(fail_count), 32'hFFFF);
    run_pattern(8'h42, ~m_img, 8'hFF, 0, -1);
    chk("sat_hold", 32'(fail_count), 32'hFFFF);
    // clear_fail coincident with the only miscompare (bit 4)
    run_pattern(8'h17, ~m_img, 8'h10, 0, 5);
    chk("clr_mis_fail", 32'(fail), 32'd1);
    chk("clr_mis_count", 32'(fail_count), 32'd1);
    chk("clr_mis_first", 32'(first_fail_pos), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
